// File: rtl/csr_access_sequencer_pkg.sv
// csr_access_sequencer_pkg: CSR op encodings, sequencer states and read-only index test
package csr_access_sequencer_pkg;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

    typedef enum logic {SRC_CORE, SRC_DBG} src_e;

    localparam int UIMM_W = 5;

    function automatic logic is_read_only(input logic [1:0] idx_hi);
        return idx_hi == 2'b11;
    endfunction

endpackage

// File: rtl/csr_access_sequencer_if.sv
// csr_req_if: one requester's CSR request/response channel
interface csr_req_if #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [CSR_ADDR_W-1:0] req_index;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_op, req_index, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_op, req_index, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/csr_access_sequencer_rmw_alu.sv
// csr_rmw_alu: new CSR value, write suppression and illegal-op detection for one access
module csr_rmw_alu
    import csr_access_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_val,
    output logic            write_suppress,
    output logic            illegal_op
);
    logic [XLEN-1:0] opnd;

    always_comb begin
        opnd           = op[2] ? {{(XLEN-UIMM_W){1'b0}}, operand[UIMM_W-1:0]} : operand;
        illegal_op     = !(op inside {CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI});
        write_suppress = (op inside {CSR_RS, CSR_RC, CSR_RSI, CSR_RCI}) && opnd == '0;
        new_val        = (op inside {CSR_RW, CSR_RWI}) ? opnd :
                         (op inside {CSR_RS, CSR_RSI}) ? (old_val | opnd) : (old_val & ~opnd);
    end
endmodule

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer: arbitrates core/debug CSR accesses and runs each as read-modify-write
module csr_access_sequencer
    import csr_access_sequencer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12,
    parameter int DBG_PRIO   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    csr_req_if.slave              core,
    csr_req_if.slave              dbg,
    output logic                  read_enable_csr,
    output logic [CSR_ADDR_W-1:0] csr_read_index,
    input  logic [XLEN-1:0]       csr_read_data,
    output logic                  write_enable_csr,
    output logic [CSR_ADDR_W-1:0] csr_write_index,
    output logic [XLEN-1:0]       csr_write_data,
    output logic                  busy
);
    state_e                state_q, state_d;
    src_e                  src_q, src_d, last_q, last_d;
    logic [2:0]            op_q, op_d;
    logic [CSR_ADDR_W-1:0] index_q, index_d;
    logic [XLEN-1:0]       wdata_q, wdata_d, old_q, old_d;
    logic                  err_q, err_d;
    logic                  re_q, re_d, we_q, we_d;
    logic [CSR_ADDR_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic [XLEN-1:0]       wr_data_q, wr_data_d, rdata_q, rdata_d;
    logic                  core_rv_q, core_rv_d, dbg_rv_q, dbg_rv_d;
    logic                  core_err_q, core_err_d, dbg_err_q, dbg_err_d;
    logic                  gnt_dbg;
    logic [2:0]            sel_op, alu_op;
    logic [CSR_ADDR_W-1:0] sel_idx;
    logic [XLEN-1:0]       sel_w, alu_w, alu_new;
    logic                  alu_supp, alu_ill;

    // In IDLE the ALU classifies the incoming request; afterwards it works on the captured one
    always_comb begin
        gnt_dbg = (core.req_valid && dbg.req_valid) ? (DBG_PRIO != 0 || last_q == SRC_CORE)
                                                    : dbg.req_valid;
        sel_op  = gnt_dbg ? dbg.req_op    : core.req_op;
        sel_idx = gnt_dbg ? dbg.req_index : core.req_index;
        sel_w   = gnt_dbg ? dbg.req_wdata : core.req_wdata;
        alu_op  = state_q == S_IDLE ? sel_op : op_q;
        alu_w   = state_q == S_IDLE ? sel_w  : wdata_q;
    end

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .op            (alu_op),
        .old_val       (csr_read_data),
        .operand       (alu_w),
        .new_val       (alu_new),
        .write_suppress(alu_supp),
        .illegal_op    (alu_ill)
    );

    assign core.req_ready = state_q == S_IDLE && core.req_valid && !gnt_dbg;
    assign dbg.req_ready  = state_q == S_IDLE && gnt_dbg;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = last_q;
        op_d    = op_q;
        index_d = index_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (core.req_valid || dbg.req_valid) begin
                src_d   = gnt_dbg ? SRC_DBG : SRC_CORE;
                last_d  = src_d;
                op_d    = sel_op;
                index_d = sel_idx;
                wdata_d = sel_w;
                err_d   = alu_ill || (is_read_only(sel_idx[CSR_ADDR_W-1 -: 2]) && !alu_supp);
                state_d = err_d ? S_RESP : S_READ;
            end
            S_READ: begin
                old_d   = csr_read_data;
                state_d = alu_supp ? S_RESP : S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
        re_d       = state_d == S_READ;
        rd_idx_d   = re_d ? index_d : '0;
        we_d       = state_d == S_WRITE;
        wr_idx_d   = we_d ? index_q : '0;
        wr_data_d  = we_d ? alu_new : '0;
        core_rv_d  = state_d == S_RESP && src_d == SRC_CORE;
        dbg_rv_d   = state_d == S_RESP && src_d == SRC_DBG;
        core_err_d = core_rv_d && err_d;
        dbg_err_d  = dbg_rv_d && err_d;
        rdata_d    = (state_d == S_RESP && !err_d) ? old_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_CORE;
            last_q     <= SRC_DBG;
            op_q       <= '0;
            index_q    <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            err_q      <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            rdata_q    <= '0;
            core_rv_q  <= 1'b0;
            dbg_rv_q   <= 1'b0;
            core_err_q <= 1'b0;
            dbg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_q     <= last_d;
            op_q       <= op_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
            old_q      <= old_d;
            err_q      <= err_d;
            re_q       <= re_d;
            we_q       <= we_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            rdata_q    <= rdata_d;
            core_rv_q  <= core_rv_d;
            dbg_rv_q   <= dbg_rv_d;
            core_err_q <= core_err_d;
            dbg_err_q  <= dbg_err_d;
        end
    end

    assign read_enable_csr  = re_q;
    assign csr_read_index   = rd_idx_q;
    assign write_enable_csr = we_q;
    assign csr_write_index  = wr_idx_q;
    assign csr_write_data   = wr_data_q;
    assign core.resp_valid  = core_rv_q;
    assign core.resp_rdata  = rdata_q;
    assign core.resp_error  = core_err_q;
    assign dbg.resp_valid   = dbg_rv_q;
    assign dbg.resp_rdata   = rdata_q;
    assign dbg.resp_error   = dbg_err_q;
    assign busy             = state_q != S_IDLE;
endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb_csr_access_sequencer: scoreboard bench with a CSR file model; second instance covers DBG_PRIO=1
module tb_csr_access_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0, rd_cnt = 0;

    typedef struct { bit dbg; logic [31:0] rdata; bit err; int due; } resp_t;
    typedef struct { logic [11:0] idx; logic [31:0] data; } wr_t;
    resp_t exp_q[$];
    wr_t   exp_w[$];
    resp_t rs_e;
    wr_t   wr_e;
    bit got_dbg, got_err;
    logic [31:0] got_rd;

    csr_req_if #(.XLEN(32), .CSR_ADDR_W(12)) core0 (), dbg0 (), core1 (), dbg1 ();

    logic        re0, we0, busy0, re1, we1, busy1;
    logic [11:0] ridx0, widx0, ridx1, widx1;
    logic [31:0] rdat0, wdat0, wdat1;
    logic [31:0] mem0 [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign rdat0 = mem0[ridx0];
    always @(negedge clk) begin
        if (we0) mem0[widx0] <= wdat0;
        else if (pre_en) mem0[pre_idx] <= pre_val;
    end

    csr_access_sequencer #(.XLEN(32), .CSR_ADDR_W(12), .DBG_PRIO(0)) dut0 (
        .clk(clk), .reset(reset), .core(core0), .dbg(dbg0),
        .read_enable_csr(re0), .csr_read_index(ridx0), .csr_read_data(rdat0),
        .write_enable_csr(we0), .csr_write_index(widx0), .csr_write_data(wdat0),
        .busy(busy0)
    );

    csr_access_sequencer #(.XLEN(32), .CSR_ADDR_W(12), .DBG_PRIO(1)) dut1 (
        .clk(clk), .reset(reset), .core(core1), .dbg(dbg1),
        .read_enable_csr(re1), .csr_read_index(ridx1), .csr_read_data(32'h0),
        .write_enable_csr(we1), .csr_write_index(widx1), .csr_write_data(wdat1),
        .busy(busy1)
    );

    // Scoreboard: every write strobe and response pulse of dut0 must match the next expectation
    always @(negedge clk) begin
        if (re0) rd_cnt++;
        if (we0) begin
            n_checks++;
            if (exp_w.size() == 0)
                $display("FAIL write_strobe: unexpected write idx=%h data=%h", widx0, wdat0);
            else begin
                wr_e = exp_w.pop_front();
                if (widx0 !== wr_e.idx || wdat0 !== wr_e.data)
                    $display("FAIL write_strobe: idx=%h data=%h, expected idx=%h data=%h",
                             widx0, wdat0, wr_e.idx, wr_e.data);
                else n_pass++;
            end
        end
        if (core0.resp_valid || dbg0.resp_valid) begin
            n_checks++;
            got_dbg = dbg0.resp_valid;
            got_rd  = got_dbg ? dbg0.resp_rdata : core0.resp_rdata;
            got_err = got_dbg ? dbg0.resp_error : core0.resp_error;
            if (exp_q.size() == 0)
                $display("FAIL resp: unexpected response dbg=%0d rdata=%h err=%0d cycle=%0d",
                         got_dbg, got_rd, got_err, cyc);
            else begin
                rs_e = exp_q.pop_front();
                if ((core0.resp_valid && dbg0.resp_valid) || got_dbg != rs_e.dbg ||
                    got_rd !== rs_e.rdata || got_err != rs_e.err || cyc != rs_e.due)
                    $display("FAIL resp: dbg=%0d rdata=%h err=%0d cycle=%0d, expected dbg=%0d rdata=%h err=%0d cycle=%0d",
                             got_dbg, got_rd, got_err, cyc, rs_e.dbg, rs_e.rdata, rs_e.err, rs_e.due);
                else n_pass++;
            end
        end
    end

    task automatic set_csr(input logic [11:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(negedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic issue(input bit dbg, input logic [2:0] op, input logic [11:0] idx,
                         input logic [31:0] w, input logic [31:0] exp_rd, input bit exp_err,
                         input int lat, input bit exp_wr, input logic [31:0] exp_wd,
                         output int acc);
        bit ok = 0;
        acc = -1;
        @(posedge clk);
        #1;
        if (dbg) begin
            dbg0.req_op = op; dbg0.req_index = idx; dbg0.req_wdata = w; dbg0.req_valid = 1'b1;
        end else begin
            core0.req_op = op; core0.req_index = idx; core0.req_wdata = w; core0.req_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg ? dbg0.req_ready : core0.req_ready) begin
                acc = cyc;
                exp_q.push_back('{dbg, exp_rd, exp_err, cyc + lat});
                if (exp_wr) exp_w.push_back('{idx, exp_wd});
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        core0.req_valid = 1'b0;
        dbg0.req_valid  = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL accept: op=%b idx=%h not accepted within 20 cycles, expected accept", op, idx);
        else n_pass++;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy0 && exp_q.size() == 0 && exp_w.size() == 0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL idle: busy=%0d pending_resp=%0d pending_wr=%0d, expected all 0",
                          busy0, exp_q.size(), exp_w.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || re0 !== 1'b0 || we0 !== 1'b0)
            $display("FAIL reset_strobes: busy=%b re=%b we=%b, expected 0 0 0", busy0, re0, we0);
        else n_pass++;
        n_checks++;
        if (core0.resp_valid !== 1'b0 || dbg0.resp_valid !== 1'b0 || wdat0 !== 32'h0 || ridx0 !== 12'h0)
            $display("FAIL reset_outputs: core_rv=%b dbg_rv=%b wdata=%h ridx=%h, expected all 0",
                     core0.resp_valid, dbg0.resp_valid, wdat0, ridx0);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || core0.req_ready !== 1'b0 || dbg0.req_ready !== 1'b0)
            $display("FAIL reset_release: busy=%b core_ready=%b dbg_ready=%b, expected 0 0 0",
                     busy0, core0.req_ready, dbg0.req_ready);
        else n_pass++;
    endtask

    task automatic test_rw();
        int n, r0;
        set_csr(12'h800, 32'h1);
        r0 = rd_cnt;
        issue(0, 3'b001, 12'h800, 32'hDEADBEEF, 32'h1, 0, 3, 1, 32'hDEADBEEF, n);
        wait_idle();
        n_checks++;
        if (mem0[12'h800] !== 32'hDEADBEEF || rd_cnt - r0 != 1)
            $display("FAIL rw_state: csr=%h reads=%0d, expected csr=deadbeef reads=1", mem0[12'h800], rd_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_suppress();
        int n;
        set_csr(12'h800, 32'hA5);
        issue(0, 3'b110, 12'h800, 32'h0, 32'hA5, 0, 2, 0, 32'h0, n);
        wait_idle();
        issue(0, 3'b111, 12'h800, 32'h5, 32'hA5, 0, 3, 1, 32'hA0, n);
        wait_idle();
        issue(0, 3'b010, 12'h800, 32'h0, 32'hA0, 0, 2, 0, 32'h0, n);
        issue(1, 3'b110, 12'h800, 32'hFFFFFF00, 32'hA0, 0, 2, 0, 32'h0, n);
        issue(0, 3'b101, 12'h800, 32'hFFFFFFE3, 32'hA0, 0, 3, 1, 32'h3, n);
        wait_idle();
        n_checks++;
        if (mem0[12'h800] !== 32'h3)
            $display("FAIL suppress_state: csr=%h, expected 00000003", mem0[12'h800]);
        else n_pass++;
    endtask

    task automatic test_errors();
        int n, r0;
        set_csr(12'hC00, 32'h77);
        r0 = rd_cnt;
        issue(0, 3'b001, 12'hC00, 32'h1234, 32'h0, 1, 1, 0, 32'h0, n);
        issue(0, 3'b100, 12'h800, 32'hFF, 32'h0, 1, 1, 0, 32'h0, n);
        issue(1, 3'b000, 12'h800, 32'hFF, 32'h0, 1, 1, 0, 32'h0, n);
        issue(0, 3'b110, 12'hC00, 32'h1, 32'h0, 1, 1, 0, 32'h0, n);
        wait_idle();
        n_checks++;
        if (rd_cnt - r0 != 0) $display("FAIL error_no_read: reads=%0d, expected 0", rd_cnt - r0);
        else n_pass++;
        issue(0, 3'b010, 12'hC00, 32'h0, 32'h77, 0, 2, 0, 32'h0, n);
        issue(1, 3'b111, 12'hC00, 32'h20, 32'h77, 0, 2, 0, 32'h0, n);
        wait_idle();
        n_checks++;
        if (rd_cnt - r0 != 2 || mem0[12'hC00] !== 32'h77)
            $display("FAIL ro_suppressed: reads=%0d csr=%h, expected reads=2 csr=00000077", rd_cnt - r0, mem0[12'hC00]);
        else n_pass++;
    endtask

    task automatic test_dbg_rc();
        int n;
        set_csr(12'h801, 32'h12345678);
        issue(1, 3'b011, 12'h801, 32'hFFFF0000, 32'h12345678, 0, 3, 1, 32'h00005678, n);
        wait_idle();
        n_checks++;
        if (mem0[12'h801] !== 32'h00005678)
            $display("FAIL dbg_rc_state: csr=%h, expected 00005678", mem0[12'h801]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        set_csr(12'h802, 32'h0);
        issue(0, 3'b001, 12'h802, 32'h11, 32'h0, 0, 3, 1, 32'h11, n1);
        issue(1, 3'b001, 12'h802, 32'h22, 32'h11, 0, 3, 1, 32'h22, n2);
        wait_idle();
        n_checks++;
        if (n2 - n1 != 4) $display("FAIL back_to_back: accept gap=%0d, expected 4", n2 - n1);
        else n_pass++;
    endtask

    task automatic test_reset_midwrite();
        int n, cnt = 0;
        bit ok = 0, seen = 0;
        set_csr(12'h801, 32'h0);
        @(posedge clk);
        #1;
        core0.req_op = 3'b001; core0.req_index = 12'h801; core0.req_wdata = 32'h55; core0.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core0.req_ready) begin
                exp_w.push_back('{12'h801, 32'h55});
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1 core0.req_valid = 1'b0;
        for (int i = 0; i < 10 && ok; i++) begin
            @(negedge clk);
            if (we0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL midwrite_strobe: write strobe not seen, expected one");
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (we0 !== 1'b0 || re0 !== 1'b0 || busy0 !== 1'b0 || core0.resp_valid !== 1'b0)
            $display("FAIL midwrite_reset: we=%b re=%b busy=%b rv=%b, expected 0 0 0 0",
                     we0, re0, busy0, core0.resp_valid);
        else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (core0.resp_valid || dbg0.resp_valid) cnt++;
        end
        n_checks++;
        if (cnt != 0 || busy0 !== 1'b0)
            $display("FAIL midwrite_noresp: responses=%0d busy=%b, expected 0 0", cnt, busy0);
        else n_pass++;
        issue(0, 3'b010, 12'h801, 32'h0, 32'h55, 0, 2, 0, 32'h0, n);
        wait_idle();
    endtask

    task automatic test_arbitration();
        int k0 = 0, k1 = 0;
        logic [2:0] gv0 = '0;
        logic [1:0] gv1 = '0;
        bit dual = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        set_csr(12'h800, 32'h3C);
        @(posedge clk);
        #1;
        core0.req_op = 3'b010; core0.req_index = 12'h800; core0.req_wdata = 32'h0; core0.req_valid = 1'b1;
        dbg0.req_op  = 3'b010; dbg0.req_index  = 12'h800; dbg0.req_wdata  = 32'h0; dbg0.req_valid  = 1'b1;
        core1.req_op = 3'b010; core1.req_index = 12'h800; core1.req_wdata = 32'h0; core1.req_valid = 1'b1;
        dbg1.req_op  = 3'b010; dbg1.req_index  = 12'h800; dbg1.req_wdata  = 32'h0; dbg1.req_valid  = 1'b1;
        for (int i = 0; i < 40 && (k0 < 3 || k1 < 2); i++) begin
            @(negedge clk);
            if (core0.req_ready && dbg0.req_ready) dual = 1;
            if (core1.req_ready && dbg1.req_ready) dual = 1;
            if (k0 < 3 && (core0.req_ready || dbg0.req_ready)) begin
                gv0[k0] = dbg0.req_ready;
                exp_q.push_back('{dbg0.req_ready, 32'h3C, 0, cyc + 2});
                k0++;
            end
            if (k1 < 2 && (core1.req_ready || dbg1.req_ready)) begin
                gv1[k1] = dbg1.req_ready;
                k1++;
            end
            @(posedge clk);
            #1;
            if (k0 == 3) begin core0.req_valid = 1'b0; dbg0.req_valid = 1'b0; end
            if (k1 == 2) begin core1.req_valid = 1'b0; dbg1.req_valid = 1'b0; end
        end
        core0.req_valid = 1'b0; dbg0.req_valid = 1'b0; core1.req_valid = 1'b0; dbg1.req_valid = 1'b0;
        n_checks++;
        if (k0 != 3 || gv0 !== 3'b010 || dual)
            $display("FAIL arb_rr: grants=%0d order=%b dual=%0d, expected 3 grants order=010 dual=0", k0, gv0, dual);
        else n_pass++;
        n_checks++;
        if (k1 != 2 || gv1 !== 2'b11)
            $display("FAIL arb_dbg_prio: grants=%0d order=%b, expected 2 grants order=11", k1, gv1);
        else n_pass++;
        wait_idle();
    endtask

    initial begin
        core0.req_valid = 1'b0; core0.req_op = '0; core0.req_index = '0; core0.req_wdata = '0;
        dbg0.req_valid  = 1'b0; dbg0.req_op  = '0; dbg0.req_index  = '0; dbg0.req_wdata  = '0;
        core1.req_valid = 1'b0; core1.req_op = '0; core1.req_index = '0; core1.req_wdata = '0;
        dbg1.req_valid  = 1'b0; dbg1.req_op  = '0; dbg1.req_index  = '0; dbg1.req_wdata  = '0;
        test_reset();
        test_rw();
        test_suppress();
        test_errors();
        test_dbg_rc();
        test_back_to_back();
        test_reset_midwrite();
        test_arbitration();
        n_checks++;
        if (exp_q.size() != 0 || exp_w.size() != 0)
            $display("FAIL leftover: pending_resp=%0d pending_wr=%0d, expected 0 0", exp_q.size(), exp_w.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
